// File: rtl/led_blink.sv
// Free-running LED blinker: divides ck into a square wave of BLINK_HZ on LED.
// Optional macro BLINK_TICK_EN adds a registered one-cycle 'tick' at each period wrap.
module led_blink #(
    parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000,
    parameter int unsigned BLINK_HZ    = 32'd1,
    parameter int unsigned CNT_W       = 32'd26
) (
    input  logic ck,
    input  logic r,
    output logic LED
`ifdef BLINK_TICK_EN
    ,
    output logic tick
`endif
);

    localparam int unsigned PERIOD = CLK_FREQ_HZ / BLINK_HZ;
    localparam int unsigned HALF   = PERIOD / 32'd2;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PERIOD - 32'd1);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Any value at or past the last count (including out-of-range ones) wraps to zero.
    always_comb begin
        w_cnt_next = '0;
        if (cnt >= LAST_C) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = cnt + ONE_C;
        end
    end

    // LED is derived from the value being loaded so it tracks cnt with no extra lag.
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            cnt <= '0;
            LED <= 1'b0;
        end else begin
            cnt <= w_cnt_next;
            LED <= (w_cnt_next >= HALF_C);
        end
    end

`ifdef BLINK_TICK_EN
    // Pulse only on a genuine wrap from the last count, never on reset release.
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST_C);
        end
    end
`endif

endmodule

// File: tb/tb_led_blink.sv
// Randomized self-checking bench for led_blink against a period/half arithmetic model.
module tb_led_blink;

    localparam int PERIOD = 50_000_000;
    localparam int HALF   = 25_000_000;

    logic ck;
    logic r;
    logic LED;
`ifdef BLINK_TICK_EN
    logic tick;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    int m_cnt;
    bit m_led;
    bit m_tick;
    logic [25:0] f_val;

    led_blink dut (
        .ck  (ck),
        .r   (r),
        .LED (LED)
`ifdef BLINK_TICK_EN
        ,
        .tick(tick)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_cnt"}, 32'(dut.cnt), 32'(m_cnt));
        check_val({tag, "_led"}, {31'd0, LED}, {31'd0, m_led});
`ifdef BLINK_TICK_EN
        check_val({tag, "_tick"}, {31'd0, tick}, {31'd0, m_tick});
`endif
    endtask

    // One clock edge: advance the model by the period rules, then compare at negedge.
    task automatic step(input string tag);
        @(posedge ck);
        m_tick = (m_cnt == PERIOD - 1);
        m_cnt  = (m_cnt >= PERIOD - 1) ? 0 : m_cnt + 1;
        m_led  = (m_cnt >= HALF);
        @(negedge ck);
        compare_all(tag);
    endtask

    // Load cnt during the low phase; LED/tick keep their values until the next edge.
    task automatic load_cnt(input logic [25:0] v);
        f_val = v;
        force dut.cnt = f_val;
        #1;
        release dut.cnt;
        m_cnt = int'(v);
    endtask

    // Drop r between edges and check the immediate asynchronous clear.
    task automatic async_reset(input string tag);
        @(posedge ck);
        #2 r = 1'b0;
        #1;
        m_cnt  = 0;
        m_led  = 1'b0;
        m_tick = 1'b0;
        compare_all(tag);
        @(negedge ck);
        r = 1'b1;
    endtask

    initial begin
        r = 1'b0;
        m_cnt = 0; m_led = 1'b0; m_tick = 1'b0;
        #1;
        compare_all("rst_imm");
        repeat (2) @(negedge ck);
        compare_all("rst_hold");
        r = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst");

        @(negedge ck);
        load_cnt(26'd24_999_995);
        for (int i = 0; i < 10; i++) step("rise");

        @(negedge ck);
        load_cnt(26'd49_999_995);
        for (int i = 0; i < 10; i++) step("wrap");

        @(negedge ck);
        load_cnt(26'd60_000_000);
        for (int i = 0; i < 3; i++) step("oor");

        @(negedge ck);
        load_cnt(26'd25_000_005);
        for (int i = 0; i < 5; i++) step("pre_arst");
        check_val("arst_led_high", {31'd0, LED}, 32'd1);
        async_reset("arst");
        for (int i = 0; i < 3; i++) step("post_arst");

        for (int it = 0; it < 40; it++) begin
            int mode;
            int base;
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                base = HALF - int'($urandom_range(1, 8));
            end else if (mode == 1) begin
                base = PERIOD - int'($urandom_range(1, 8));
            end else begin
                base = int'($urandom_range(0, 67_108_863));
            end
            @(negedge ck);
            load_cnt(26'(base));
            for (int k = 0; k < int'($urandom_range(1, 12)); k++) step("rnd");
            if ($urandom_range(0, 4) == 0) begin
                async_reset("rnd_arst");
                step("rnd_after_arst");
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
